// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Sequential unsigned restoring divider. A start pulse accepted in IDLE
// captures a dividend/divisor pair. One quotient bit is produced per clock
// over WIDTH clocks. Quotient, remainder and a divide-by-zero flag are then
// presented together with a one-cycle done pulse. A zero divisor takes a
// single-cycle shortcut that returns an all-ones quotient and the dividend
// as the remainder.
//
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous active-high reset
//   start        operation request, only looked at while idle
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   quotient     registered result, updates only when done asserts
//   remainder    registered result, updates only when done asserts
//   busy         high while an operation is in progress
//   done         one-cycle pulse when results are valid
//   div_by_zero  flag for the last completed operation, updates with done
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZERO = 2'd2
    } StateT;

    StateT              r_state;
    logic [WIDTH-1:0]   r_shiftQ;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH:0]     r_partRem;
    logic [CNT_W-1:0]   r_iterCnt;

    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_qNext;
    logic [WIDTH:0]     w_remNext;
    logic               w_lastIter;

    // One restoring step: bring the next dividend bit into the partial
    // remainder and trial-subtract the divisor. A clear MSB on the trial
    // result means the subtraction fit, so the quotient bit is 1 and the
    // trial value becomes the new partial remainder.
    always_comb begin
        w_remShift = {r_partRem[WIDTH-1:0], r_shiftQ[WIDTH-1]};
        w_trial    = w_remShift - {1'b0, r_divisor};
        w_qNext    = {r_shiftQ[WIDTH-2:0], ~w_trial[WIDTH]};
        w_remNext  = w_trial[WIDTH] ? w_remShift : w_trial;
        w_lastIter = (r_iterCnt == CNT_W'(WIDTH - 1));
    end

    // Control FSM and datapath registers. done is cleared every edge so it
    // can only ever last one cycle. The results are loaded straight from the
    // final step's combinational values so they appear on the same edge as
    // done.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= IDLE;
            r_shiftQ    <= '0;
            r_divisor   <= '0;
            r_partRem   <= '0;
            r_iterCnt   <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shiftQ <= dividend;
                        busy     <= 1'b1;
                        if (divisor == '0) begin
                            r_state <= ZERO;
                        end else begin
                            r_divisor <= divisor;
                            r_partRem <= '0;
                            r_iterCnt <= '0;
                            r_state   <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    r_shiftQ  <= w_qNext;
                    r_partRem <= w_remNext;
                    r_iterCnt <= r_iterCnt + CNT_W'(1);
                    if (w_lastIter) begin
                        quotient    <= w_qNext;
                        remainder   <= w_remNext[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                ZERO: begin
                    quotient    <= '1;
                    remainder   <= r_shiftQ;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential unsigned restoring divider for the arithmetic datapath. It is the inverse-operation companion to the Booth multiplier and shares its operand width and start/done control style. It accepts a dividend/divisor pair on a start pulse and produces one quotient bit per clock. When finished it presents quotient and remainder with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand/quotient/remainder width in bits (>= 2)
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator, unsigned; captured on accepted start
divisor  input  WIDTH  denominator, unsigned; captured on accepted start
quotient  output  WIDTH  result; registered, updates only when done asserts
remainder  output  WIDTH  result; registered, updates only when done asserts
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results are valid
div_by_zero  output  1  registered flag for the last completed operation; updates with done

Behaviour:
- Reset (clr high, asynchronous): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- Reset release: the first edge after clr falls is a normal edge.
- States:
  - IDLE: waits for start.
  - BUSY: runs WIDTH restoring iterations.
  - ZERO: single-cycle divide-by-zero path.
- IDLE, start=1, divisor!=0:
  - Capture the dividend into shift register Q and the divisor into D.
  - Clear partial remainder R (WIDTH+1 bits) and counter.
  - busy=1, go to BUSY.
- IDLE, start=1, divisor==0:
  - Capture the dividend, busy=1, go to ZERO.
- BUSY iteration, one per edge:
  - Form R' = {R[WIDTH-1:0], Q[WIDTH-1]} and shift Q left by 1.
  - T = R' - {1'b0,D}.
  - If T is non-negative (MSB 0): R=T, Q[0]=1. Otherwise R=R', Q[0]=0.
  - Counter increments.
- On the WIDTH-th iteration edge:
  - quotient = final Q, remainder = final R[WIDTH-1:0], div_by_zero=0.
  - done=1, busy=0, state=IDLE.
- ZERO, next edge:
  - quotient = all ones, remainder = captured dividend, div_by_zero=1.
  - done=1, busy=0, state=IDLE.
- Latency, taking E0 as the edge that accepts start:
  - Normal: done is high in the cycle after edge E0+WIDTH (WIDTH clocks after acceptance).
  - Divide-by-zero: done is high after edge E0+1.
- done is high for exactly one cycle. quotient, remainder and div_by_zero hold until the next completion.
- start while busy=1 is ignored; captured operands are unaffected.
- start in the same cycle as done=1 is accepted (state is IDLE). This gives back-to-back throughput of one result per WIDTH+1 clocks.
- Operand inputs are don't-care except in the accepting cycle.
- Quotient/remainder identity: dividend == quotient*divisor + remainder, with remainder < divisor, for all divisor != 0.

Test Plan:
- Reset then 100/7 (WIDTH=16): start one cycle -> busy for 16 cycles, done pulse after edge E0+16, quotient=14, remainder=2, div_by_zero=0.
- Boundary operands: 0xFFFF/1 -> q=0xFFFF, r=0. 5/9 -> q=0, r=5. 0/3 -> q=0, r=0. 0xFFFF/0xFFFF -> q=1, r=0.
- Divide by zero: 1234/0 -> done after E0+1, q=0xFFFF, r=1234, div_by_zero=1. A following 10/3 -> q=3, r=1, div_by_zero=0.
- start re-asserted with 50/5 during busy of 200/9 -> ignored. Result q=22, r=2, exactly one done pulse.
- Back-to-back: start held high continuously with 1000/10 then 999/10 -> second accepted in the done cycle. Results 100/0 then 99/9, done pulses 17 cycles apart.
- clr pulsed asynchronously (mid-cycle) at iteration 8 of 60000/7 -> all outputs 0 immediately, no done. A fresh 60000/7 -> q=8571, r=3.
